uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Round-robin arbiter that shares one uart_tx_supervisor (string-level UART transmitter) between NUM_REQ independent requesters, such as the LCD status reporter and the debug console.
- Each requester presents a packed string and a byte length, holds its request, and receives a one-cycle completion pulse.
- The arbiter latches the winner's data, launches the supervisor, waits for its done pulse, then rotates priority.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 112, string bits per requester; must equal supervisor i_txData width
- MAX_LEN, 14, maximum bytes per string (DATA_WIDTH/8)
- TIMEOUT_CYCLES, 0, cycles allowed in WAIT before abort; 0 disables the watchdog

Ports:
- i_clock  in  1  system clock
- i_reset  in  1  asynchronous, active-high reset
- i_req  in  NUM_REQ  level request per requester; held until matching o_done
- i_reqData  in  NUM_REQ*DATA_WIDTH  packed strings; requester k at [k*DATA_WIDTH +: DATA_WIDTH]
- i_reqLength  in  NUM_REQ*8  byte counts; requester k at [k*8 +: 8]
- o_grant  out  NUM_REQ  one-hot current owner; 0 when idle
- o_done  out  NUM_REQ  one-cycle completion pulse to the owner
- o_timeout  out  1  one-cycle pulse coincident with o_done when the watchdog aborted the transfer
- o_txBegin  out  1  to supervisor i_txBegin
- o_txData  out  DATA_WIDTH  to supervisor i_txData
- o_txDataLength  out  8  to supervisor i_txDataLength
- i_txBusy  in  1  from supervisor o_txBusy
- i_txDone  in  1  from supervisor o_txDone

Behaviour:
- Reset (async, i_reset=1):
  - all outputs 0
  - state IDLE
  - priority pointer 0
  - watchdog counter 0
- Outputs are registered.
- IDLE:
  - Eligible when any i_req is high AND i_txBusy=0. The supervisor has no reset, so it may still be busy after an arbiter reset; never launch while it is busy.
  - Winner = first set request at or after the pointer, scanning upward and wrapping modulo NUM_REQ.
  - On the winning edge:
    - o_grant = onehot(winner)
    - o_txData = winner's slice
    - o_txDataLength = min(length, MAX_LEN); lengths above 14 would index outside the data word
    - next state LAUNCH
- LAUNCH: o_txBegin=1 for exactly this one cycle; next state WAIT.
- WAIT:
  - o_txBegin=0.
  - On i_txDone=1, go to COMPLETE.
  - If TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES, go to COMPLETE with the timeout flag set.
  - The counter increments each WAIT cycle and clears on entry to WAIT.
- COMPLETE (one cycle):
  - o_done[winner]=1, o_timeout = timeout flag
  - o_grant cleared
  - pointer = (winner+1) mod NUM_REQ
  - next state IDLE
- Latency: request seen in IDLE at edge N gives o_txBegin high during cycle N+1. o_done pulses 1 cycle after i_txDone is sampled.
- Length 0: launched normally; the supervisor emits no bytes and pulses done; the requester gets o_done.
- Request dropped mid-transfer: the transfer completes; o_done still pulses to the recorded winner.
- Request still high after o_done: the requester stays eligible, but the rotated pointer gives other requesters priority first.
- Data changes after grant: ignored, because data is latched at grant.
- Simultaneous requests: resolved only by the pointer scan; exactly one grant.
- i_txDone outside WAIT: ignored.
- Reset mid-transfer: the arbiter returns to IDLE immediately and waits for i_txBusy=0 before the next launch. No o_done is issued for the interrupted transfer.

Decomposition:
- Shared include uart_arb_defs.vh holds:
  - state encodings: s_IDLE=0, s_LAUNCH=1, s_WAIT=2, s_COMPLETE=3 (2-bit)
  - UART_MAX_LEN=14
  - UART_DATA_WIDTH=112
- Sub-module rr_priority_picker:
  - combinational: inputs request vector and pointer; outputs a valid flag and the winner index
  - reusable by other shared-resource arbiters

Test Plan:
- Single request: i_req=0001, length 3, data ending 0x414243 -> o_grant=0001; o_txBegin one cycle at N+1; o_txDataLength=3; o_done=0001 one cycle after i_txDone.
- All four requesting continuously from reset -> grants in order 0,1,2,3,0; o_done pulses in the same order; no overlapping grants.
- Length 20 on requester 2 -> o_txDataLength=14; length 0 -> o_done still pulses, supervisor sends nothing.
- TIMEOUT_CYCLES=50 with i_txDone tied low -> o_done and o_timeout pulse together 50 WAIT cycles after launch; the pointer still advances.
- Assert i_reset during WAIT while i_txBusy=1 -> outputs 0 asynchronously; a pending request gets no o_txBegin until i_txBusy falls; first grant goes to the lowest requesting index.
- Requester 1 drops i_req mid-transfer and changes i_reqData -> the transfer completes with the latched data; o_done=0010.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter_pkg
// Shared definitions for the UART transmit arbiter slice: arbiter state
// encoding, default string geometry of the uart_tx_supervisor and a helper
// that clamps a requested byte count to what the data word can hold.
// ----------------------------------------------------------------------------
package uart_tx_arbiter_pkg;

    // Geometry of the shared string-level transmitter.
    localparam int unsigned UART_MAX_LEN    = 14;
    localparam int unsigned UART_DATA_WIDTH = 112;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StLaunch   = 2'd1,
        StWait     = 2'd2,
        StComplete = 2'd3
    } arbState_e;

    // Lengths past maxLen would make the supervisor index outside its data word.
    function automatic logic [7:0] clampLength(input logic [7:0] len,
                                               input int unsigned maxLen);
        logic [7:0] limit;
        limit = 8'(maxLen);
        return (len > limit) ? limit : len;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// ----------------------------------------------------------------------------
// rr_priority_picker
// Combinational round-robin picker. Returns the first set request at or after
// the pointer, scanning upward and wrapping modulo NUM_REQ. Usable by any
// arbiter sharing one resource between several requesters.
//
// Ports:
//   i_req     request vector, one bit per requester
//   i_ptr     index holding the highest priority this round (< NUM_REQ)
//   o_valid   at least one request is set
//   o_winner  index of the chosen requester (0 when o_valid is low)
// ----------------------------------------------------------------------------
module rr_priority_picker
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic               o_valid,
    output logic [IDX_W-1:0]   o_winner
);

    // Walk from the farthest offset to the nearest so the nearest hit is the
    // last assignment and therefore the one that sticks.
    always_comb begin
        o_valid  = 1'b0;
        o_winner = '0;
        for (int off = int'(NUM_REQ) - 1; off >= 0; off--) begin
            int               pos;
            logic [IDX_W-1:0] sel;
            pos = int'(i_ptr) + off;
            if (pos >= int'(NUM_REQ)) begin
                pos = pos - int'(NUM_REQ);
            end
            sel = IDX_W'(pos);
            if (i_req[sel]) begin
                o_valid  = 1'b1;
                o_winner = sel;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one uart_tx_supervisor between NUM_REQ requesters with round-robin
// priority. The winner's string and length are latched at grant, the
// supervisor is launched with a one-cycle begin pulse, and the owner gets a
// one-cycle done pulse when the supervisor finishes (or the optional watchdog
// gives up). Priority then rotates to the requester after the owner.
//
// Ports:
//   i_clock, i_reset  clock, asynchronous active-high reset
//   i_req             level request per requester, held until its o_done
//   i_reqData         packed strings, requester k at [k*DATA_WIDTH +: DATA_WIDTH]
//   i_reqLength       byte counts, requester k at [k*8 +: 8]
//   o_grant           one-hot current owner, 0 when idle
//   o_done            one-cycle completion pulse to the owner
//   o_timeout         pulses with o_done when the watchdog aborted the transfer
//   o_txBegin         supervisor launch pulse
//   o_txData          latched string for the supervisor
//   o_txDataLength    latched, clamped byte count for the supervisor
//   i_txBusy          supervisor busy
//   i_txDone          supervisor done pulse
// All outputs are registered.
// ----------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned DATA_WIDTH     = UART_DATA_WIDTH,
    parameter int unsigned MAX_LEN        = UART_MAX_LEN,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_reqData,
    input  logic [NUM_REQ*8-1:0]          i_reqLength,
    output logic [NUM_REQ-1:0]            o_grant,
    output logic [NUM_REQ-1:0]            o_done,
    output logic                          o_timeout,
    output logic                          o_txBegin,
    output logic [DATA_WIDTH-1:0]         o_txData,
    output logic [7:0]                    o_txDataLength,
    input  logic                          i_txBusy,
    input  logic                          i_txDone
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arbState_e              stateQ, stateD;
    logic [IDX_W-1:0]       ptrQ, ptrD;
    logic [IDX_W-1:0]       ownerQ, ownerD;
    logic [31:0]            wdCntQ, wdCntD;

    logic [NUM_REQ-1:0]     grantQ, grantD;
    logic [NUM_REQ-1:0]     doneQ, doneD;
    logic                   timeoutQ, timeoutD;
    logic                   txBeginQ, txBeginD;
    logic [DATA_WIDTH-1:0]  txDataQ, txDataD;
    logic [7:0]             txLenQ, txLenD;

    logic                   pickValid;
    logic [IDX_W-1:0]       pickIdx;
    logic                   launch;
    logic                   wdExpired;
    logic                   finish;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .i_req    (i_req),
        .i_ptr    (ptrQ),
        .o_valid  (pickValid),
        .o_winner (pickIdx)
    );

    // The supervisor has no reset of its own, so it can still be busy after
    // an arbiter reset; a launch is only allowed once it has gone quiet.
    assign launch    = (stateQ == StIdle) && pickValid && !i_txBusy;
    // Fires on the edge that ends the TIMEOUT_CYCLES-th WAIT cycle.
    assign wdExpired = (TIMEOUT_CYCLES != 0) && ((wdCntQ + 32'd1) == TIMEOUT_CYCLES);
    assign finish    = (stateQ == StWait) && (i_txDone || wdExpired);

    // State register.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            stateQ <= StIdle;
        end else begin
            stateQ <= stateD;
        end
    end

    // Next-state logic.
    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            StIdle:     if (launch) stateD = StLaunch;
            StLaunch:   stateD = StWait;
            StWait:     if (finish) stateD = StComplete;
            StComplete: stateD = StIdle;
            default:    stateD = StIdle;
        endcase
    end

    // Output and datapath next values; everything lands in registers so the
    // begin pulse coincides with LAUNCH and the done pulse with COMPLETE.
    always_comb begin
        grantD   = grantQ;
        txDataD  = txDataQ;
        txLenD   = txLenQ;
        ownerD   = ownerQ;
        ptrD     = ptrQ;
        wdCntD   = wdCntQ;
        doneD    = '0;
        timeoutD = 1'b0;
        txBeginD = 1'b0;

        unique case (stateQ)
            StIdle: begin
                if (launch) begin
                    grantD   = NUM_REQ'(1) << pickIdx;
                    ownerD   = pickIdx;
                    txBeginD = 1'b1;
                    for (int k = 0; k < int'(NUM_REQ); k++) begin
                        if (pickIdx == IDX_W'(k)) begin
                            txDataD = i_reqData[k*DATA_WIDTH +: DATA_WIDTH];
                            txLenD  = clampLength(i_reqLength[k*8 +: 8], MAX_LEN);
                        end
                    end
                end
            end
            StLaunch: begin
                wdCntD = '0;
            end
            StWait: begin
                wdCntD = wdCntQ + 32'd1;
                if (finish) begin
                    doneD    = NUM_REQ'(1) << ownerQ;
                    // A real done in the same cycle wins over the watchdog.
                    timeoutD = !i_txDone;
                    grantD   = '0;
                    ptrD     = (ownerQ == IDX_W'(NUM_REQ - 1)) ? '0 : ownerQ + 1'b1;
                end
            end
            StComplete: begin
            end
            default: begin
            end
        endcase
    end

    // Output and datapath registers.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            grantQ   <= '0;
            doneQ    <= '0;
            timeoutQ <= 1'b0;
            txBeginQ <= 1'b0;
            txDataQ  <= '0;
            txLenQ   <= '0;
            ownerQ   <= '0;
            ptrQ     <= '0;
            wdCntQ   <= '0;
        end else begin
            grantQ   <= grantD;
            doneQ    <= doneD;
            timeoutQ <= timeoutD;
            txBeginQ <= txBeginD;
            txDataQ  <= txDataD;
            txLenQ   <= txLenD;
            ownerQ   <= ownerD;
            ptrQ     <= ptrD;
            wdCntQ   <= wdCntD;
        end
    end

    assign o_grant        = grantQ;
    assign o_done         = doneQ;
    assign o_timeout      = timeoutQ;
    assign o_txBegin      = txBeginQ;
    assign o_txData       = txDataQ;
    assign o_txDataLength = txLenQ;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Scoreboard bench: directed stimulus pushes expected launches and completions
// into queues; a monitor pops and compares whenever the arbiter presents a
// begin or done pulse. A small supervisor model answers launches.
// ----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int NR  = 4;
    localparam int DW  = 112;
    localparam int TMO = 50;

    typedef struct {
        logic [NR-1:0] grant;
        logic [7:0]    len;
        logic [DW-1:0] data;
    } launch_t;

    typedef struct {
        logic [NR-1:0] done;
        logic          tmo;
    } done_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req;
    logic [NR*DW-1:0]  reqData;
    logic [NR*8-1:0]   reqLen;
    logic [NR-1:0]     grant;
    logic [NR-1:0]     done;
    logic              timeout;
    logic              txBegin;
    logic [DW-1:0]     txData;
    logic [7:0]        txLen;
    logic              busy;
    logic              hold;
    logic              txBusy;
    logic              txDone;
    logic              txDoneAtEdge = 1'b0;

    int                svLat;
    bit                svNoDone;

    launch_t           launchQ[$];
    done_t             doneQ[$];
    int                checks = 0;
    int                errors = 0;

    int                cyc = 0;
    int                beginCyc = 0;
    bit                prevBegin = 1'b0;

    always #5 clk = ~clk;

    assign txBusy = busy | hold;

    always @(posedge clk) txDoneAtEdge <= txDone;

    uart_tx_arbiter #(
        .NUM_REQ        (NR),
        .DATA_WIDTH     (DW),
        .MAX_LEN        (14),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .i_clock        (clk),
        .i_reset        (rst),
        .i_req          (req),
        .i_reqData      (reqData),
        .i_reqLength    (reqLen),
        .o_grant        (grant),
        .o_done         (done),
        .o_timeout      (timeout),
        .o_txBegin      (txBegin),
        .o_txData       (txData),
        .o_txDataLength (txLen),
        .i_txBusy       (txBusy),
        .i_txDone       (txDone)
    );

    task automatic check(input string name, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic setReq(input int k, input logic [DW-1:0] d, input logic [7:0] l);
        reqData[k*DW +: DW] = d;
        reqLen[k*8 +: 8]    = l;
    endtask

    task automatic expLaunch(input logic [NR-1:0] g, input logic [7:0] l,
                             input logic [DW-1:0] d);
        launch_t e;
        e.grant = g;
        e.len   = l;
        e.data  = d;
        launchQ.push_back(e);
    endtask

    task automatic expDone(input logic [NR-1:0] g, input logic t);
        done_t e;
        e.done = g;
        e.tmo  = t;
        doneQ.push_back(e);
    endtask

    task automatic waitDone(input int k);
        int n;
        n = 0;
        @(negedge clk);
        while (!done[k] && n < 300) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("wait_done_%0d", k), DW'(done[k]), DW'(1));
    endtask

    task automatic waitBegin();
        int n;
        n = 0;
        while (!txBegin && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("wait_begin", DW'(txBegin), DW'(1));
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_grant"},   DW'(grant),   DW'(0));
        check({tag, "_done"},    DW'(done),    DW'(0));
        check({tag, "_timeout"}, DW'(timeout), DW'(0));
        check({tag, "_begin"},   DW'(txBegin), DW'(0));
        check({tag, "_len"},     DW'(txLen),   DW'(0));
        check({tag, "_data"},    txData,       DW'(0));
    endtask

    // Supervisor model: goes busy on a launch and pulses done svLat cycles
    // later, or (svNoDone) never answers and waits for the arbiter to give up.
    initial begin
        int n;
        busy   = 1'b0;
        txDone = 1'b0;
        forever begin
            @(negedge clk);
            if (txBegin) begin
                busy = 1'b1;
                if (svNoDone) begin
                    n = 0;
                    while (done == '0 && n < 300) begin
                        @(negedge clk);
                        n++;
                    end
                end else begin
                    repeat (svLat) @(negedge clk);
                    txDone = 1'b1;
                    @(negedge clk);
                    txDone = 1'b0;
                end
                busy = 1'b0;
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        launch_t e;
        done_t   d;
        forever begin
            @(negedge clk);
            cyc++;
            if (txBegin) begin
                check("begin_width", DW'(prevBegin), DW'(0));
                if (launchQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_launch: got grant %b, expected no launch", grant);
                end else begin
                    e = launchQ.pop_front();
                    check("launch_grant", DW'(grant), DW'(e.grant));
                    check("launch_len",   DW'(txLen), DW'(e.len));
                    check("launch_data",  txData,     e.data);
                end
                beginCyc = cyc;
            end
            prevBegin = txBegin;
            if (done != '0) begin
                if (doneQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done %b, expected none", done);
                end else begin
                    d = doneQ.pop_front();
                    check("done_vec",     DW'(done),    DW'(d.done));
                    check("done_timeout", DW'(timeout), DW'(d.tmo));
                    check("done_grant_cleared", DW'(grant), DW'(0));
                    if (d.tmo) begin
                        check("timeout_delay", DW'(cyc - beginCyc), DW'(TMO + 1));
                    end else begin
                        check("done_latency", DW'(txDoneAtEdge), DW'(1));
                    end
                end
            end
        end
    end

    initial begin
        rst      = 1'b1;
        req      = '0;
        reqData  = '0;
        reqLen   = '0;
        hold     = 1'b0;
        svLat    = 3;
        svNoDone = 1'b0;
        #1;
        checkAllZero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Single request, latency and begin width.
        setReq(0, 112'h414243, 8'd3);
        expLaunch(4'b0001, 8'd3, 112'h414243);
        expDone(4'b0001, 1'b0);
        @(negedge clk);
        req[0] = 1'b1;
        @(negedge clk);
        check("t1_begin_n1", DW'(txBegin), DW'(1));
        check("t1_grant",    DW'(grant),   DW'(4'b0001));
        @(negedge clk);
        check("t1_begin_off", DW'(txBegin), DW'(0));
        waitDone(0);
        req[0] = 1'b0;

        // All four requesting from reset: 0,1,2,3,0.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < NR; k++) begin
            setReq(k, DW'(32'hC0DE0000 + k), 8'(k + 1));
        end
        for (int i = 0; i < 5; i++) begin
            expLaunch(4'(1 << (i % NR)), 8'((i % NR) + 1), DW'(32'hC0DE0000 + (i % NR)));
            expDone(4'(1 << (i % NR)), 1'b0);
        end
        req = 4'b1111;
        waitDone(0);
        waitDone(1);
        waitDone(2);
        waitDone(3);
        waitDone(0);
        req = '0;

        // Length clamp and zero length (pointer now 1).
        setReq(2, 112'h0102030405060708090A0B0C0D0E, 8'd20);
        expLaunch(4'b0100, 8'd14, 112'h0102030405060708090A0B0C0D0E);
        expDone(4'b0100, 1'b0);
        req[2] = 1'b1;
        waitDone(2);
        req[2] = 1'b0;
        setReq(1, 112'h5A5A, 8'd0);
        expLaunch(4'b0010, 8'd0, 112'h5A5A);
        expDone(4'b0010, 1'b0);
        req[1] = 1'b1;
        waitDone(1);
        req[1] = 1'b0;

        // Watchdog abort (pointer now 2), then confirm the pointer advanced.
        svNoDone = 1'b1;
        setReq(3, 112'h7E7E7E, 8'd5);
        expLaunch(4'b1000, 8'd5, 112'h7E7E7E);
        expDone(4'b1000, 1'b1);
        req[3] = 1'b1;
        waitDone(3);
        req[3] = 1'b0;
        svNoDone = 1'b0;
        setReq(0, 112'h3030, 8'd2);
        expLaunch(4'b0001, 8'd2, 112'h3030);
        expDone(4'b0001, 1'b0);
        expLaunch(4'b1000, 8'd5, 112'h7E7E7E);
        expDone(4'b1000, 1'b0);
        req = 4'b1001;
        waitDone(0);
        req[0] = 1'b0;
        waitDone(3);
        req[3] = 1'b0;

        // Reset during WAIT while the supervisor stays busy.
        svLat = 30;
        setReq(1, 112'hAAAA, 8'd6);
        expLaunch(4'b0010, 8'd6, 112'hAAAA);
        req[1] = 1'b1;
        @(negedge clk);
        waitBegin();
        repeat (5) @(negedge clk);
        hold = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        checkAllZero("async_reset");
        @(negedge clk);
        rst = 1'b0;
        setReq(3, 112'hBBBB, 8'd7);
        req = 4'b1010;
        repeat (40) @(negedge clk);
        check("busy_block_grant", DW'(grant),   DW'(0));
        check("busy_block_begin", DW'(txBegin), DW'(0));
        svLat = 3;
        expLaunch(4'b0010, 8'd6, 112'hAAAA);
        expDone(4'b0010, 1'b0);
        expLaunch(4'b1000, 8'd7, 112'hBBBB);
        expDone(4'b1000, 1'b0);
        hold = 1'b0;
        waitDone(1);
        req[1] = 1'b0;
        waitDone(3);
        req[3] = 1'b0;

        // Requester 1 drops its request and changes data mid-transfer.
        svLat = 8;
        setReq(1, 112'hC1C2C3C4, 8'd4);
        expLaunch(4'b0010, 8'd4, 112'hC1C2C3C4);
        expDone(4'b0010, 1'b0);
        req[1] = 1'b1;
        @(negedge clk);
        waitBegin();
        repeat (2) @(negedge clk);
        req[1] = 1'b0;
        setReq(1, 112'hDEADBEEF, 8'd9);
        @(negedge clk);
        check("latched_data",  txData,     112'hC1C2C3C4);
        check("latched_len",   DW'(txLen), DW'(4));
        check("latched_grant", DW'(grant), DW'(4'b0010));
        waitDone(1);

        repeat (5) @(negedge clk);
        check("launch_queue_empty", DW'(launchQ.size()), DW'(0));
        check("done_queue_empty",   DW'(doneQ.size()),   DW'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
